// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants and FSM encoding for the interrupt controller
package interrupt_controller_pkg;

  localparam int               NUM_SRC    = 4;
  localparam logic [4:0]       RET_OPCODE = 5'b10000;
  localparam logic [NUM_SRC-1:0] MASK_RESET = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_DRAIN   = 2'd3
  } intc_state_e;

endpackage

// File: rtl/intc_priority_enc.sv
// rtl/intc_priority_enc.sv - fixed-priority selector, lowest set index wins
module intc_priority_enc
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [1:0]         idx,
  output logic               valid
);

  always_comb begin
    idx   = 2'd0;
    valid = |req;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = i[1:0];
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched 4-source interrupt controller; INTC_SYNC_EN adds irq synchronizers
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [23:0]        ins,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               interrupt,
  output logic [1:0]         irq_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] irq_prev;

`ifdef INTC_SYNC_EN
  localparam int ARM_DEPTH = 3;
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end
  assign irq_s = sync2;
`else
  localparam int ARM_DEPTH = 1;
  assign irq_s = irq;
`endif

  // Edge detection stays disarmed until the sampling path has filled after
  // reset, so a line held high across reset never looks like a new edge.
  logic [ARM_DEPTH-1:0] arm;
  logic                 edge_en;
  assign edge_en = arm[ARM_DEPTH-1];

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] service_clr;
  logic [NUM_SRC-1:0] enc_req;
  logic [1:0]         enc_idx;
  logic               enc_valid;
  logic               is_ret;
  logic               unused_ins;

  intc_state_e state, state_next;
  logic [1:0]  id_next;

  assign rise        = irq_s & ~irq_prev & {NUM_SRC{edge_en}};
  assign service_clr = (state == ST_FIRE) ? (NUM_SRC'(1) << irq_id) : '0;
  assign enc_req     = pending & ~mask;
  assign is_ret      = (ins[23:19] == RET_OPCODE);
  assign unused_ins  = ^ins[18:0];

  intc_priority_enc u_prio (
    .req   (enc_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_next = state;
    id_next    = irq_id;
    case (state)
      ST_IDLE: begin
        if (enc_valid) begin
          state_next = ST_FIRE;
          id_next    = enc_idx;
        end
      end
      ST_FIRE:    state_next = ST_SERVICE;
      ST_SERVICE: if (is_ret) state_next = ST_DRAIN;
      ST_DRAIN:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      irq_id    <= 2'd0;
      interrupt <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      irq_prev  <= '0;
      mask      <= MASK_RESET;
      arm       <= '0;
    end else begin
      state     <= state_next;
      irq_id    <= id_next;
      interrupt <= (state_next == ST_FIRE);
      busy      <= (state_next != ST_IDLE);
      // Set after clear: a fresh edge on the source being retired survives.
      pending   <= (pending & ~service_clr) | rise;
      irq_prev  <= irq_s;
      arm       <= (arm << 1) | ARM_DEPTH'(1);
      if (mask_we) mask <= mask_wdata;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [23:0] ins;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        interrupt;
  logic [1:0]  irq_id;
  logic        busy;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int errors = 0;
  int checks = 0;

  localparam logic [23:0] INS_RET   = 24'h800000;
  localparam logic [23:0] INS_OTHER = 24'h123456;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ins        (ins),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .busy       (busy),
    .pending    (pending),
    .mask       (mask)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic write_mask(input logic [3:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    cyc();
    mask_we    = 1'b0;
  endtask

  task automatic finish_service();
    ins = INS_RET;
    cyc();
    ins = 24'h0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = 4'h0; ins = 24'h0; mask_we = 1'b0; mask_wdata = 4'h0;
    cyc();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt got=%b exp=0", interrupt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_irq_id got=%0d exp=0", irq_id); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    checks++; if (mask !== 4'hF) begin errors++; $display("FAIL reset_mask got=%h exp=f", mask); end
    reset = 1'b1;
    cyc(); cyc();
  endtask

  task automatic test_single();
    write_mask(4'h0);
    irq = 4'b0100;
    cyc();
    irq = 4'b0000;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending_set got=%b exp=0100", pending); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", interrupt); end
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL single_fire got=%b exp=1", interrupt); end
    checks++; if (irq_id !== 2'd2) begin errors++; $display("FAIL single_irq_id got=%0d exp=2", irq_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    cyc();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_one_cycle got=%b exp=0", interrupt); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL single_pending_clr got=%b exp=0000", pending); end
    ins = INS_RET;
    cyc();
    ins = 24'h0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_drain_busy got=%b exp=1", busy); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    cyc();
    irq = 4'b0000;
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_first_fire got=%b exp=1", interrupt); end
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL prio_first_id got=%0d exp=1", irq_id); end
    cyc();
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_pending got=%b exp=1000", pending); end
    finish_service();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", interrupt); end
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL prio_second_fire got=%b exp=1", interrupt); end
    checks++; if (irq_id !== 2'd3) begin errors++; $display("FAIL prio_second_id got=%0d exp=3", irq_id); end
    cyc();
    finish_service();
  endtask

  task automatic test_mask();
    int cnt;
    write_mask(4'b0001);
    irq = 4'b0001;
    cyc();
    irq = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (interrupt) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL mask_blocked got=%0d exp=0", cnt); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL mask_pending got=%b exp=0001", pending); end
    write_mask(4'h0);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_old_used got=%b exp=0", interrupt); end
    checks++; if (mask !== 4'h0) begin errors++; $display("FAIL mask_value got=%h exp=0", mask); end
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL mask_fire got=%b exp=1", interrupt); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL mask_irq_id got=%0d exp=0", irq_id); end
    cyc();
    finish_service();
  endtask

  task automatic test_no_nesting();
    int cnt;
    irq = 4'b1000;
    cyc();
    irq = 4'b0000;
    cyc();
    cyc();
    irq = 4'b0100;
    cyc();
    irq = 4'b0000;
    ins = INS_OTHER;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (interrupt) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL nest_no_fire got=%0d exp=0", cnt); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL nest_pending got=%b exp=0100", pending); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nest_busy got=%b exp=1", busy); end
    ins = INS_RET;
    cyc();
    ins = 24'h0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nest_drain got=%b exp=1", busy); end
    cyc();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_idle got=%b exp=0", interrupt); end
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL nest_fire got=%b exp=1", interrupt); end
    checks++; if (irq_id !== 2'd2) begin errors++; $display("FAIL nest_irq_id got=%0d exp=2", irq_id); end
    cyc();
    finish_service();
  endtask

  task automatic test_set_wins();
    irq = 4'b0010;
    cyc();
    irq = 4'b0000;
    cyc();
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL setwin_fire got=%b exp=1", interrupt); end
    irq = 4'b0010;
    cyc();
    irq = 4'b0000;
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL setwin_pending got=%b exp=0010", pending); end
    finish_service();
    cyc();
    checks++; if (interrupt !== 1'b1 || irq_id !== 2'd1) begin
      errors++; $display("FAIL setwin_refire got=%b/%0d exp=1/1", interrupt, irq_id);
    end
    cyc();
    finish_service();
  endtask

  task automatic test_reset_mid();
    int  cnt;
    bit  seen;
    irq = 4'b0010;
    cyc(); cyc(); cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_in_service got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rmid_pending got=%b exp=0000", pending); end
    checks++; if (mask !== 4'hF) begin errors++; $display("FAIL rmid_mask got=%h exp=f", mask); end
    cyc();
    reset = 1'b1;
    cyc();
    write_mask(4'h0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (interrupt) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rmid_held_no_edge got=%0d exp=0", cnt); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rmid_held_pending got=%b exp=0000", pending); end
    irq = 4'b0000;
    cyc();
    irq = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc();
      if (interrupt) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rmid_toggle_fire got=%b exp=1", seen); end
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL rmid_irq_id got=%0d exp=1", irq_id); end
    irq = 4'b0000;
    cyc();
    finish_service();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_nesting();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
